// File: rtl/vending_pkg.sv
// Shared definitions for the coin-change dispenser.
//   COIN_Q/COIN_D/COIN_N : coin values in cents
//   state_e              : payout sequencer states (3-bit encoding)
//   coin_sel_e           : which coin is currently selected for release
//   coin_value()         : cents value of a coin select code
package vending_pkg;

   localparam logic [7:0] COIN_Q = 8'd25;
   localparam logic [7:0] COIN_D = 8'd10;
   localparam logic [7:0] COIN_N = 8'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_WAIT   = 3'd2,
      ST_PULSE  = 3'd3,
      ST_GAP    = 3'd4,
      ST_FIN    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_Q    = 2'd1,
      SEL_D    = 2'd2,
      SEL_N    = 2'd3
   } coin_sel_e;

   function automatic logic [7:0] coin_value(input coin_sel_e sel);
      logic [7:0] v;
      case (sel)
         SEL_Q:   v = COIN_Q;
         SEL_D:   v = COIN_D;
         SEL_N:   v = COIN_N;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Bundle between the vending controller / dispenser side (master) and the
// change dispense sequencer (slave).
//   master drives : start, amount, mech_ready, load_q/d/n, load_val
//   slave drives  : busy, done, short, remaining, relq/reld/reln, cnt_q/d/n
interface change_dispense_ctrl_if #(
   parameter int INV_W = 6
);
   logic             start;
   logic [7:0]       amount;
   logic             mech_ready;
   logic             load_q;
   logic             load_d;
   logic             load_n;
   logic [INV_W-1:0] load_val;

   logic             busy;
   logic             done;
   logic             short;
   logic [7:0]       remaining;
   logic             relq;
   logic             reld;
   logic             reln;
   logic [INV_W-1:0] cnt_q;
   logic [INV_W-1:0] cnt_d;
   logic [INV_W-1:0] cnt_n;

   modport master (
      output start, amount, mech_ready, load_q, load_d, load_n, load_val,
      input  busy, done, short, remaining, relq, reld, reln, cnt_q, cnt_d, cnt_n
   );

   modport slave (
      input  start, amount, mech_ready, load_q, load_d, load_n, load_val,
      output busy, done, short, remaining, relq, reld, reln, cnt_q, cnt_d, cnt_n
   );

endinterface

// File: rtl/change_dispense_ctrl_inv.sv
// coin_inventory: three coin stock counters.
//   clk, reset             : clock, synchronous active-high reset (to INIT_*)
//   load_q/d/n_i, load_val_i : refill strobes (caller gates them to IDLE)
//   dec_sel_i              : coin to decrement this cycle (SEL_NONE = hold)
//   cnt_q/d/n_o            : current counts
//   nz_q/d/n_o             : count is nonzero
module coin_inventory
   import vending_pkg::*;
#(
   parameter int INV_W  = 6,
   parameter int INIT_Q = 10,
   parameter int INIT_D = 10,
   parameter int INIT_N = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_q_i,
   input  logic             load_d_i,
   input  logic             load_n_i,
   input  logic [INV_W-1:0] load_val_i,
   input  coin_sel_e        dec_sel_i,
   output logic [INV_W-1:0] cnt_q_o,
   output logic [INV_W-1:0] cnt_d_o,
   output logic [INV_W-1:0] cnt_n_o,
   output logic             nz_q_o,
   output logic             nz_d_o,
   output logic             nz_n_o
);

   logic [INV_W-1:0] qcnt_q, dcnt_q, ncnt_q;

   // Decrement is guarded by the nonzero flag so a count can never wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         qcnt_q <= INV_W'(INIT_Q);
         dcnt_q <= INV_W'(INIT_D);
         ncnt_q <= INV_W'(INIT_N);
      end else begin
         if (load_q_i)                          qcnt_q <= load_val_i;
         else if (dec_sel_i == SEL_Q && nz_q_o) qcnt_q <= qcnt_q - INV_W'(1);
         if (load_d_i)                          dcnt_q <= load_val_i;
         else if (dec_sel_i == SEL_D && nz_d_o) dcnt_q <= dcnt_q - INV_W'(1);
         if (load_n_i)                          ncnt_q <= load_val_i;
         else if (dec_sel_i == SEL_N && nz_n_o) ncnt_q <= ncnt_q - INV_W'(1);
      end
   end

   assign cnt_q_o = qcnt_q;
   assign cnt_d_o = dcnt_q;
   assign cnt_n_o = ncnt_q;
   assign nz_q_o  = |qcnt_q;
   assign nz_d_o  = |dcnt_q;
   assign nz_n_o  = |ncnt_q;

endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: greedy coin-change payout sequencer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of change_dispense_ctrl_if
//                (start/amount request, mech_ready handshake, refill loads;
//                 busy/done/short/remaining status, rel* pulses, counts)
// Each coin: SELECT -> WAIT (until mech_ready) -> PULSE -> GAP cycles.
// All outputs decode from registered state only.
module change_dispense_ctrl
   import vending_pkg::*;
#(
   parameter int GAP    = 1,
   parameter int INV_W  = 6,
   parameter int INIT_Q = 10,
   parameter int INIT_D = 10,
   parameter int INIT_N = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   change_dispense_ctrl_if.slave   bus
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_e         state_q, state_d;
   coin_sel_e      sel_q, sel_d;
   logic [7:0]     remaining_q, remaining_d;
   logic           short_q, short_d;
   logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

   logic             nz_q, nz_d, nz_n;
   logic [INV_W-1:0] cnt_q, cnt_d, cnt_n;
   logic             idle;
   coin_sel_e        dec_sel;

   logic busy_o, done_o, relq_o, reld_o, reln_o;

   // Refills only land in IDLE; a decrement is applied at the end of PULSE
   // (a reset in that same cycle wins, so the pulse shows but is not counted).
   assign idle    = (state_q == ST_IDLE);
   assign dec_sel = (state_q == ST_PULSE) ? sel_q : SEL_NONE;

   coin_inventory #(
      .INV_W  (INV_W),
      .INIT_Q (INIT_Q),
      .INIT_D (INIT_D),
      .INIT_N (INIT_N)
   ) u_inv (
      .clk        (clk),
      .reset      (reset),
      .load_q_i   (bus.load_q & idle),
      .load_d_i   (bus.load_d & idle),
      .load_n_i   (bus.load_n & idle),
      .load_val_i (bus.load_val),
      .dec_sel_i  (dec_sel),
      .cnt_q_o    (cnt_q),
      .cnt_d_o    (cnt_d),
      .cnt_n_o    (cnt_n),
      .nz_q_o     (nz_q),
      .nz_d_o     (nz_d),
      .nz_n_o     (nz_n)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sel_q       <= SEL_NONE;
         remaining_q <= 8'd0;
         short_q     <= 1'b0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         remaining_q <= remaining_d;
         short_q     <= short_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      remaining_d = remaining_q;
      short_d     = short_q;
      gap_cnt_d   = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               remaining_d = bus.amount;
               short_d     = 1'b0;
               state_d     = ST_SELECT;
            end
         end
         ST_SELECT: begin
            state_d = ST_WAIT;
            if (remaining_q >= COIN_Q && nz_q)      sel_d = SEL_Q;
            else if (remaining_q >= COIN_D && nz_d) sel_d = SEL_D;
            else if (remaining_q >= COIN_N && nz_n) sel_d = SEL_N;
            else begin
               // Nothing payable: short is latched here so it is valid alongside done.
               sel_d   = SEL_NONE;
               short_d = (remaining_q != 8'd0);
               state_d = ST_FIN;
            end
         end
         ST_WAIT: begin
            if (bus.mech_ready) state_d = ST_PULSE;
         end
         ST_PULSE: begin
            remaining_d = remaining_q - coin_value(sel_q);
            gap_cnt_d   = '0;
            state_d     = (GAP == 0) ? ST_SELECT : ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ST_SELECT;
            else                       gap_cnt_d = gap_cnt_q + GW'(1);
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      busy_o = (state_q != ST_IDLE);
      done_o = (state_q == ST_FIN);
      relq_o = (state_q == ST_PULSE) && (sel_q == SEL_Q);
      reld_o = (state_q == ST_PULSE) && (sel_q == SEL_D);
      reln_o = (state_q == ST_PULSE) && (sel_q == SEL_N);
   end

   assign bus.busy      = busy_o;
   assign bus.done      = done_o;
   assign bus.short     = short_q;
   assign bus.remaining = remaining_q;
   assign bus.relq      = relq_o;
   assign bus.reld      = reld_o;
   assign bus.reln      = reln_o;
   assign bus.cnt_q     = cnt_q;
   assign bus.cnt_d     = cnt_d;
   assign bus.cnt_n     = cnt_n;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: requests push an expected
// payout (computed from greedy min() arithmetic on a model inventory); a
// monitor checks every release pulse, its cycle, and the done report.
module tb_change_dispense_ctrl;

   localparam int GAP_P  = 1;
   localparam int INV_W  = 6;
   localparam int INIT_C = 10;

   typedef struct {
      int rem;
      int shrt;
      int nq, nd, nn;
      int cq, cd, cn;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   change_dispense_ctrl_if #(.INV_W(INV_W)) bus();

   change_dispense_ctrl #(
      .GAP(GAP_P), .INV_W(INV_W), .INIT_Q(INIT_C), .INIT_D(INIT_C), .INIT_N(INIT_C)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_chk, n_fail;
   exp_t exp_q[$];
   int   dly_q[$];
   int   mq, md, mn;
   int   dly_mode;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- mech_ready responder ----------------
   // After each accepted start / pulse, choose how many WAIT cycles
   // mech_ready stays low and hold it low long enough to cover them.
   int r_low, r_d, r_base;
   bit r_busy_prev;
   initial begin
      bus.mech_ready = 1'b1;
      r_low = 0;
      r_busy_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            r_low = 0;
            r_busy_prev = 1'b0;
         end else begin
            r_base = 0;
            if (bus.busy && !r_busy_prev) r_base = 1;
            if (bus.relq || bus.reld || bus.reln) r_base = 2 + GAP_P;
            if (r_base != 0) begin
               if (dly_mode == 1)      r_d = 5;
               else if (dly_mode == 2) r_d = int'($urandom_range(0, 3));
               else                    r_d = 0;
               dly_q.push_back(r_d);
               r_low = r_base + r_d;
            end
            r_busy_prev = bus.busy;
         end
         bus.mech_ready = (r_low == 0);
         if (r_low > 0) r_low--;
      end
   end

   // ---------------- monitor ----------------
   int   cyc, last_ev, kpulse, m_nrel, m_code, m_exp, m_d;
   bit   in_txn, busy_prev, rel_prev;
   exp_t cur;
   initial begin
      cyc = 0; in_txn = 0; busy_prev = 0; rel_prev = 0; kpulse = 0; last_ev = 0;
      forever begin
         @(negedge clk);
         cyc++;
         m_nrel = int'(bus.relq) + int'(bus.reld) + int'(bus.reln);
         if (reset) begin
            in_txn = 0; busy_prev = 0; rel_prev = 0;
         end else begin
            if (bus.busy && !busy_prev) begin
               chk("pending_requests", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  in_txn = 1; kpulse = 0; last_ev = cyc;
               end
            end
            if (m_nrel != 0) begin
               chk("rel_onehot", m_nrel, 1);
               chk("rel_adjacent", int'(rel_prev), 0);
               chk("rel_in_txn", int'(in_txn), 1);
               if (in_txn) begin
                  m_code = bus.relq ? 1 : (bus.reld ? 2 : 3);
                  m_exp  = (kpulse < cur.nq) ? 1 : ((kpulse < cur.nq + cur.nd) ? 2 : 3);
                  chk("coin_kind", m_code, m_exp);
                  m_d = 0;
                  if (dly_q.size() > 0) m_d = dly_q.pop_front();
                  chk("pulse_cycle", cyc, last_ev + ((kpulse == 0) ? 2 : 3 + GAP_P) + m_d);
                  kpulse++;
                  last_ev = cyc;
               end
            end
            if (bus.done) begin
               chk("done_in_txn", int'(in_txn), 1);
               if (in_txn) begin
                  chk("done_busy", int'(bus.busy), 1);
                  chk("coin_count", kpulse, cur.nq + cur.nd + cur.nn);
                  chk("done_cycle", cyc, last_ev + ((kpulse == 0) ? 1 : 2 + GAP_P));
                  chk("done_remaining", int'(bus.remaining), cur.rem);
                  chk("done_short", int'(bus.short), cur.shrt);
                  chk("done_cnt_q", int'(bus.cnt_q), cur.cq);
                  chk("done_cnt_d", int'(bus.cnt_d), cur.cd);
                  chk("done_cnt_n", int'(bus.cnt_n), cur.cn);
                  in_txn = 0;
                  dly_q.delete();
               end
            end
            busy_prev = bus.busy;
            rel_prev  = (m_nrel != 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_load(input bit lq, input bit ld, input bit ln, input int val);
      @(negedge clk);
      bus.load_q = lq; bus.load_d = ld; bus.load_n = ln;
      bus.load_val = INV_W'(val);
      @(negedge clk);
      bus.load_q = 1'b0; bus.load_d = 1'b0; bus.load_n = 1'b0;
      if (lq) mq = val;
      if (ld) md = val;
      if (ln) mn = val;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_busy"},      int'(bus.busy), 0);
      chk({tag, "_done"},      int'(bus.done), 0);
      chk({tag, "_short"},     int'(bus.short), 0);
      chk({tag, "_rel"},       int'(bus.relq) + int'(bus.reld) + int'(bus.reln), 0);
      chk({tag, "_remaining"}, int'(bus.remaining), 0);
      chk({tag, "_cnt_q"},     int'(bus.cnt_q), INIT_C);
      chk({tag, "_cnt_d"},     int'(bus.cnt_d), INIT_C);
      chk({tag, "_cnt_n"},     int'(bus.cnt_n), INIT_C);
   endtask

   // poke: mid-payout start + load_q that must be ignored.
   // rst_cyc: nonzero asserts reset sampled at the end of that cycle.
   task automatic run_txn(input int amt, input bit poke, input int rst_cyc);
      exp_t e;
      int a;
      a = amt;
      e.nq = (a / 25 < mq) ? a / 25 : mq;  a = a - 25 * e.nq;
      e.nd = (a / 10 < md) ? a / 10 : md;  a = a - 10 * e.nd;
      e.nn = (a / 5  < mn) ? a / 5  : mn;  a = a - 5 * e.nn;
      e.rem  = a;
      e.shrt = (a != 0) ? 1 : 0;
      e.cq = mq - e.nq; e.cd = md - e.nd; e.cn = mn - e.nn;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.amount = amt[7:0];
      @(negedge clk);
      bus.start  = 1'b0;
      bus.amount = 8'($urandom);
      if (poke) begin
         repeat (4) @(negedge clk);
         bus.start = 1'b1; bus.amount = 8'd5;
         bus.load_q = 1'b1; bus.load_val = INV_W'(3);
         @(negedge clk);
         bus.start = 1'b0; bus.load_q = 1'b0;
      end
      if (rst_cyc > 0) begin
         repeat (rst_cyc - 1) @(negedge clk);
         reset = 1'b1;
         repeat (2) @(negedge clk);
         reset = 1'b0;
         exp_q.delete();
         dly_q.delete();
         mq = INIT_C; md = INIT_C; mn = INIT_C;
         check_reset_state("midrst");
         return;
      end
      mq = e.cq; md = e.cd; mn = e.cn;
      for (int i = 0; i < 3000 && bus.busy; i++) @(negedge clk);
      chk("txn_end_busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      chk("held_remaining", int'(bus.remaining), e.rem);
      chk("held_short", int'(bus.short), e.shrt);
      chk("done_width", int'(bus.done), 0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      mq = INIT_C; md = INIT_C; mn = INIT_C;
      dly_mode = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.amount = 8'd0;
      bus.load_q = 1'b0; bus.load_d = 1'b0; bus.load_n = 1'b0;
      bus.load_val = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_state("reset");

      run_txn(40, 0, 0);
      chk("t40_cnt_q", int'(bus.cnt_q), 9);
      chk("t40_cnt_d", int'(bus.cnt_d), 9);
      chk("t40_cnt_n", int'(bus.cnt_n), 9);

      do_load(1, 0, 0, 1);
      do_load(0, 1, 0, 3);
      do_load(0, 0, 1, 0);
      run_txn(30, 0, 0);
      chk("t30_cnt_d", int'(bus.cnt_d), 3);
      chk("t30_remaining", int'(bus.remaining), 5);

      do_load(1, 1, 1, 10);
      dly_mode = 1;
      run_txn(100, 0, 0);
      dly_mode = 0;

      run_txn(0, 0, 0);
      run_txn(7, 0, 0);
      run_txn(65, 1, 0);
      run_txn(65, 0, 7);
      run_txn(40, 0, 0);

      do_load(1, 1, 1, 2);
      run_txn(85, 0, 0);

      dly_mode = 2;
      for (int t = 0; t < 25; t++) begin
         if ($urandom_range(0, 2) == 0)
            do_load(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 12)));
         run_txn(int'($urandom_range(0, 255)), 0, 0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
